// File: rtl/queue_calc_sequencer.sv
// -----------------------------------------------------------------------------
// queue_calc_sequencer
//
// Purpose:
//   Sequences a token stream (operands and operators) into commands for an
//   attached 8-bit queue and evaluates a postfix expression. Operands are
//   pushed. A binary operator pops the two head entries and pushes
//   A op B, where A is entry 0 and B is entry 1. Eval pops the single
//   remaining entry and reports it as the result. Errors are sticky until rst.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset (shared with the queue)
//   in_valid       in   token present
//   in_ready       out  token accepted when in_valid && in_ready at an edge
//   in_is_op       in   0 = operand, 1 = operator
//   in_data[7:0]   in   operand value, or operator code in bits [2:0]
//   q_opcode[1:0]  out  queue command: 00 push, 10 pair-pop/push, 11 pop, 01 nop
//   q_back[7:0]    out  data for the queue command
//   q_top_conc     in   queue head pair: [15:8] entry 0, [7:0] entry 1
//   q_pos_back     in   queue occupancy
//   result[7:0]    out  final evaluated value
//   result_valid   out  one-cycle pulse qualifying result
//   err            out  sticky error flag
//   err_code[1:0]  out  01 overflow, 10 underflow, 11 illegal operator
// -----------------------------------------------------------------------------
module queue_calc_sequencer #(
    parameter int DEPTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_op,
    input  logic [7:0]  in_data,
    output logic [1:0]  q_opcode,
    output logic [7:0]  q_back,
    input  logic [15:0] q_top_conc,
    input  logic [2:0]  q_pos_back,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int DATA_W = 8;
    localparam logic [2:0] DEPTH_Q = 3'(DEPTH);

    localparam logic [1:0] QC_PUSH = 2'b00;
    localparam logic [1:0] QC_NOP  = 2'b01;
    localparam logic [1:0] QC_PAIR = 2'b10;
    localparam logic [1:0] QC_POP  = 2'b11;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_OVER  = 2'b01;
    localparam logic [1:0] EC_UNDER = 2'b10;
    localparam logic [1:0] EC_ILL   = 2'b11;

    localparam logic [2:0] OP_ILL  = 3'b110;
    localparam logic [2:0] OP_EVAL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // All arithmetic wraps modulo 256; mul keeps the low byte of the product.
    function automatic logic [DATA_W-1:0] alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = a ^ b;
            3'b101:  alu = prod[DATA_W-1:0];
            default: alu = '0;
        endcase
    endfunction

    state_t            r_state;
    logic [1:0]        r_q_opcode;
    logic [DATA_W-1:0] r_q_back;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_err;
    logic [1:0]        r_err_code;

    state_t            w_state_nxt;
    logic [1:0]        w_q_opcode_nxt;
    logic [DATA_W-1:0] w_q_back_nxt;
    logic [DATA_W-1:0] w_result_nxt;
    logic              w_result_valid_nxt;
    logic              w_err_nxt;
    logic [1:0]        w_err_code_nxt;

    logic              w_accept;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [2:0]        w_op;

    assign w_a      = q_top_conc[15:8];
    assign w_b      = q_top_conc[7:0];
    assign w_op     = in_data[2:0];
    // rst is folded in so no token can be taken on the reset edge.
    assign in_ready = (r_state == S_IDLE) && !r_err && !rst;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_q_opcode_nxt     = QC_NOP;
        w_q_back_nxt       = r_q_back;
        w_result_nxt       = r_result;
        w_result_valid_nxt = 1'b0;
        w_err_nxt          = r_err;
        w_err_code_nxt     = r_err_code;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!in_is_op) begin
                        if (q_pos_back >= DEPTH_Q) begin
                            w_state_nxt    = S_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = EC_OVER;
                        end else begin
                            w_state_nxt    = S_CMD;
                            w_q_opcode_nxt = QC_PUSH;
                            w_q_back_nxt   = in_data;
                        end
                    end else if (w_op == OP_ILL) begin
                        w_state_nxt    = S_ERR;
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = EC_ILL;
                    end else if (w_op == OP_EVAL) begin
                        if (q_pos_back == 3'd1) begin
                            w_state_nxt    = S_CMD;
                            w_q_opcode_nxt = QC_POP;
                            w_q_back_nxt   = w_a;
                            w_result_nxt   = w_a;
                        end else begin
                            w_state_nxt    = S_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = EC_UNDER;
                        end
                    end else begin
                        if (q_pos_back >= 3'd2) begin
                            w_state_nxt    = S_CMD;
                            w_q_opcode_nxt = QC_PAIR;
                            w_q_back_nxt   = alu(w_op, w_a, w_b);
                        end else begin
                            w_state_nxt    = S_ERR;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = EC_UNDER;
                        end
                    end
                end
            end
            S_CMD: begin
                // A pop-front command is only ever issued by eval.
                if (r_q_opcode == QC_POP) begin
                    w_state_nxt        = S_DONE;
                    w_result_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_ERR;
                w_err_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_q_opcode     <= QC_NOP;
            r_q_back       <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= EC_NONE;
        end else begin
            r_state        <= w_state_nxt;
            r_q_opcode     <= w_q_opcode_nxt;
            r_q_back       <= w_q_back_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_err          <= w_err_nxt;
            r_err_code     <= w_err_code_nxt;
        end
    end

    assign q_opcode     = r_q_opcode;
    assign q_back       = r_q_back;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign err          = r_err;
    assign err_code     = r_err_code;

endmodule

// File: tb/tb_queue_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_queue_calc_sequencer
//
// Purpose:
//   Directed bench for queue_calc_sequencer. A small behavioural queue is
//   attached so postfix sequences evaluate end to end; each token row carries
//   its hand-computed queue command, data, occupancy and result.
// -----------------------------------------------------------------------------
module tb_queue_calc_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_op;
    logic [7:0]  in_data;
    logic [1:0]  q_opcode;
    logic [7:0]  q_back;
    logic [15:0] q_top_conc;
    logic [2:0]  q_pos_back;
    logic [7:0]  result;
    logic        result_valid;
    logic        err;
    logic [1:0]  err_code;

    int n_total = 0;
    int n_bad   = 0;

    queue_calc_sequencer #(.DEPTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_op     (in_is_op),
        .in_data      (in_data),
        .q_opcode     (q_opcode),
        .q_back       (q_back),
        .q_top_conc   (q_top_conc),
        .q_pos_back   (q_pos_back),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural queue: push at back, pair-pop from front then push result,
    // pop-front; acts on the command it sees at each rising edge.
    logic [7:0] qm [0:7];
    int         qcnt;

    always @(posedge clk) begin
        if (rst) begin
            qcnt <= 0;
        end else begin
            case (q_opcode)
                2'b00: if (qcnt < 8) begin
                    qm[qcnt] <= q_back;
                    qcnt     <= qcnt + 1;
                end
                2'b10: if (qcnt >= 2) begin
                    for (int i = 0; i < 6; i++) qm[i] <= qm[i+2];
                    qm[qcnt-2] <= q_back;
                    qcnt       <= qcnt - 1;
                end
                2'b11: if (qcnt >= 1) begin
                    for (int i = 0; i < 7; i++) qm[i] <= qm[i+1];
                    qcnt <= qcnt - 1;
                end
                default: ;
            endcase
        end
    end

    assign q_top_conc = {qm[0], qm[1]};
    assign q_pos_back = 3'(qcnt);

    typedef struct {
        logic       is_op;
        logic [7:0] data;
        logic [1:0] exp_op;
        logic [7:0] exp_back;
        int         exp_pos;
        logic [7:0] exp_res;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] last_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rst_in_ready_edge", 32'(in_ready), 32'd0);
        chk("rst_q_opcode", 32'(q_opcode), 32'd1);
        chk("rst_q_back", 32'(q_back), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        last_res = 8'd0;
        #1;
    endtask

    task automatic drive(input logic is_op, input logic [7:0] data);
        wait_ready();
        in_valid = 1'b1;
        in_is_op = is_op;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic run_row(input vec_t v);
        bit is_eval;
        is_eval = v.is_op && (v.data[2:0] == 3'b111);
        drive(v.is_op, v.data);
        chk("cmd_opcode", 32'(q_opcode), 32'(v.exp_op));
        if (!is_eval) chk("cmd_back", 32'(q_back), 32'(v.exp_back));
        chk("cmd_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("post_cmd_opcode", 32'(q_opcode), 32'd1);
        if (is_eval) begin
            chk("done_valid", 32'(result_valid), 32'd1);
            chk("done_result", 32'(result), 32'(v.exp_res));
            chk("done_in_ready", 32'(in_ready), 32'd0);
            last_res = v.exp_res;
            tick();
            chk("valid_one_cycle", 32'(result_valid), 32'd0);
        end else begin
            chk("no_valid", 32'(result_valid), 32'd0);
            chk("result_hold", 32'(result), 32'(last_res));
        end
        chk("q_pos", 32'(q_pos_back), 32'(v.exp_pos));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_is_op = 1'b0;
        in_data  = 8'd0;
        last_res = 8'd0;

        //              is_op data   exp_op exp_back pos res
        vt.push_back('{1'b0, 8'd3,   2'b00, 8'd3,    1, 8'd0});
        vt.push_back('{1'b0, 8'd4,   2'b00, 8'd4,    2, 8'd0});
        vt.push_back('{1'b1, 8'd0,   2'b10, 8'd7,    1, 8'd0});
        vt.push_back('{1'b1, 8'd7,   2'b11, 8'd0,    0, 8'd7});
        vt.push_back('{1'b0, 8'd10,  2'b00, 8'd10,   1, 8'd0});
        vt.push_back('{1'b0, 8'd3,   2'b00, 8'd3,    2, 8'd0});
        vt.push_back('{1'b1, 8'd1,   2'b10, 8'd7,    1, 8'd0});
        vt.push_back('{1'b1, 8'd7,   2'b11, 8'd0,    0, 8'd7});
        vt.push_back('{1'b0, 8'd3,   2'b00, 8'd3,    1, 8'd0});
        vt.push_back('{1'b0, 8'd10,  2'b00, 8'd10,   2, 8'd0});
        vt.push_back('{1'b1, 8'd1,   2'b10, 8'd249,  1, 8'd0});
        vt.push_back('{1'b1, 8'd7,   2'b11, 8'd0,    0, 8'd249});
        vt.push_back('{1'b0, 8'd20,  2'b00, 8'd20,   1, 8'd0});
        vt.push_back('{1'b0, 8'd13,  2'b00, 8'd13,   2, 8'd0});
        vt.push_back('{1'b1, 8'd5,   2'b10, 8'd4,    1, 8'd0});
        vt.push_back('{1'b1, 8'd7,   2'b11, 8'd0,    0, 8'd4});
        // 12 & 10 = 8; 8 | 6 = 14; 14 ^ 11 = 5 (upper data bits of an operator ignored)
        vt.push_back('{1'b0, 8'd12,  2'b00, 8'd12,   1, 8'd0});
        vt.push_back('{1'b0, 8'd10,  2'b00, 8'd10,   2, 8'd0});
        vt.push_back('{1'b1, 8'hF2,  2'b10, 8'd8,    1, 8'd0});
        vt.push_back('{1'b0, 8'd6,   2'b00, 8'd6,    2, 8'd0});
        vt.push_back('{1'b1, 8'd3,   2'b10, 8'd14,   1, 8'd0});
        vt.push_back('{1'b0, 8'd11,  2'b00, 8'd11,   2, 8'd0});
        vt.push_back('{1'b1, 8'd4,   2'b10, 8'd5,    1, 8'd0});
        vt.push_back('{1'b1, 8'd7,   2'b11, 8'd0,    0, 8'd5});

        #2;
        do_reset();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vt.size(); i++) run_row(vt[i]);

        // Overflow: five pushes fill the queue, the sixth errors out.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_row('{1'b0, 8'(i + 1), 2'b00, 8'(i + 1), i + 1, 8'd0});
        drive(1'b0, 8'd6);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_code", 32'(err_code), 32'd1);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_opcode", 32'(q_opcode), 32'd1);
        in_valid = 1'b1;
        in_is_op = 1'b0;
        in_data  = 8'd99;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        chk("ovf_pos", 32'(q_pos_back), 32'd5);
        chk("ovf_sticky", 32'(err), 32'd1);
        chk("ovf_sticky_code", 32'(err_code), 32'd1);
        chk("ovf_opcode_hold", 32'(q_opcode), 32'd1);

        // Underflow on a binary operator with one entry.
        do_reset();
        run_row('{1'b0, 8'd5, 2'b00, 8'd5, 1, 8'd0});
        drive(1'b1, 8'd0);
        chk("unf_err", 32'(err), 32'd1);
        chk("unf_code", 32'(err_code), 32'd2);
        tick();
        chk("unf_pos", 32'(q_pos_back), 32'd1);
        do_reset();

        // Illegal operator straight after reset.
        drive(1'b1, 8'd6);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_code", 32'(err_code), 32'd3);
        do_reset();

        // Eval on an empty queue is an underflow.
        drive(1'b1, 8'd7);
        chk("eval_empty_code", 32'(err_code), 32'd2);
        chk("eval_empty_valid", 32'(result_valid), 32'd0);
        do_reset();

        // Reset during the CMD cycle of a push aborts it.
        drive(1'b0, 8'd9);
        chk("abort_cmd_opcode", 32'(q_opcode), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort_opcode", 32'(q_opcode), 32'd1);
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_pos", 32'(q_pos_back), 32'd0);

        // Reset during the CMD cycle of an eval suppresses the result pulse.
        run_row('{1'b0, 8'd42, 2'b00, 8'd42, 1, 8'd0});
        drive(1'b1, 8'd7);
        chk("abort_eval_opcode", 32'(q_opcode), 32'd3);
        rst = 1'b1;
        tick();
        chk("abort_eval_valid", 32'(result_valid), 32'd0);
        chk("abort_eval_result", 32'(result), 32'd0);
        chk("abort_eval_opcode_nop", 32'(q_opcode), 32'd1);
        rst = 1'b0;
        tick();
        chk("abort_eval_valid2", 32'(result_valid), 32'd0);
        chk("abort_eval_pos", 32'(q_pos_back), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
